fp_add_arbiter: RTL and testbench



---
 rtl/fp_add_pkg.sv | 40 ++++
 rtl/rsp_fifo.sv | 57 +++++
 rtl/fp_add_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared constants, types and helpers for the shared-adder arbiter
package fp_add_pkg;

  localparam int LAT    = 5;
  localparam int DEPTH  = 8;
  localparam int CRED_W = 4;
  localparam int RSP_W  = 42;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        sign;
    logic [7:0]  exp;
  } rsp_t;

  typedef struct packed {
    logic    vld;
    req_id_e id;
  } tag_t;

  // A simultaneous take and give leaves the credit count where it was.
  function automatic logic [CRED_W-1:0] cred_next(input logic [CRED_W-1:0] cred,
                                                  input logic take,
                                                  input logic give);
    logic [CRED_W-1:0] r;
    r = cred;
    if (take && !give) begin
      r = cred - CRED_W'(1);
    end else if (give && !take) begin
      r = cred + CRED_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// rtl/rsp_fifo.sv - first-word fall-through result FIFO with synchronous clear
module rsp_fifo
  import fp_add_pkg::*;
#(
  parameter int N = DEPTH,
  parameter int W = RSP_W
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic [W-1:0]  mem [N];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  // Output is forced to zero while empty so nothing stale leaks out after clear.
  assign data   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(N - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(N - 1)) ? '0 : rd_ptr + AW'(1);
      end
      if (push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin, credit-gated sharing of one pipelined adder by two requesters
module fp_add_arbiter
  import fp_add_pkg::*;
(
  input  logic        clk,
  input  logic        clear,

  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r0_cin,
  input  logic        r0_sign,
  input  logic [7:0]  r0_exp,

  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic        r1_cin,
  input  logic        r1_sign,
  input  logic [7:0]  r1_exp,

  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  output logic        add_s,
  output logic [7:0]  add_e,
  output logic [31:0] add_n1,
  output logic [31:0] add_n2,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  input  logic        add_S,
  input  logic [7:0]  add_E,

  output logic        q0_valid,
  input  logic        q0_ready,
  output logic [31:0] q0_sum,
  output logic        q0_cout,
  output logic        q0_sign,
  output logic [7:0]  q0_exp,

  output logic        q1_valid,
  input  logic        q1_ready,
  output logic [31:0] q1_sum,
  output logic        q1_cout,
  output logic        q1_sign,
  output logic [7:0]  q1_exp
);

  logic [CRED_W-1:0] cred0;
  logic [CRED_W-1:0] cred1;
  req_id_e           last;
  tag_t              tag_pipe [LAT];

  logic    elig0, elig1;
  logic    grant0, grant1;
  logic    issue;
  req_id_e grant_id;
  logic    pop0, pop1;
  logic    push0, push1;
  tag_t    ret_tag;
  rsp_t    rsp_in;
  rsp_t    rsp0, rsp1;

  // Arbitration: a requester needs a credit, i.e. a reserved FIFO slot for its result.
  always_comb begin
    elig0  = r0_valid && (cred0 != '0);
    elig1  = r1_valid && (cred1 != '0);
    grant0 = !clear && elig0 && (!elig1 || (last == REQ1));
    grant1 = !clear && elig1 && (!elig0 || (last == REQ0));
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign issue    = grant0 || grant1;
  assign grant_id = grant1 ? REQ1 : REQ0;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    add_s   = 1'b0;
    add_e   = '0;
    if (grant0) begin
      add_a   = r0_a;
      add_b   = r0_b;
      add_cin = r0_cin;
      add_s   = r0_sign;
      add_e   = r0_exp;
    end else if (grant1) begin
      add_a   = r1_a;
      add_b   = r1_b;
      add_cin = r1_cin;
      add_s   = r1_sign;
      add_e   = r1_exp;
    end
  end

  assign add_n1 = '0;
  assign add_n2 = '0;

  assign pop0 = q0_valid && q0_ready;
  assign pop1 = q1_valid && q1_ready;

  // The tag pipe mirrors the adder depth; its last stage labels the sum now on add_sum.
  always_ff @(posedge clk) begin
    if (clear) begin
      cred0 <= CRED_W'(DEPTH);
      cred1 <= CRED_W'(DEPTH);
      last  <= REQ1;
      for (int i = 0; i < LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      cred0 <= cred_next(cred0, grant0, pop0);
      cred1 <= cred_next(cred1, grant1, pop1);
      if (issue) begin
        last <= grant_id;
      end
      tag_pipe[0] <= '{vld: issue, id: grant_id};
      for (int i = 1; i < LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign ret_tag = tag_pipe[LAT-1];
  assign push0   = ret_tag.vld && (ret_tag.id == REQ0);
  assign push1   = ret_tag.vld && (ret_tag.id == REQ1);
  assign rsp_in  = '{sum: add_sum, cout: add_cout, sign: add_S, exp: add_E};

  rsp_fifo #(
    .N (DEPTH),
    .W (RSP_W)
  ) u_fifo0 (
    .clk       (clk),
    .clear     (clear),
    .push      (push0),
    .push_data (rsp_in),
    .pop       (q0_ready),
    .valid     (q0_valid),
    .data      (rsp0)
  );

  rsp_fifo #(
    .N (DEPTH),
    .W (RSP_W)
  ) u_fifo1 (
    .clk       (clk),
    .clear     (clear),
    .push      (push1),
    .push_data (rsp_in),
    .pop       (q1_ready),
    .valid     (q1_valid),
    .data      (rsp1)
  );

  assign q0_sum  = rsp0.sum;
  assign q0_cout = rsp0.cout;
  assign q0_sign = rsp0.sign;
  assign q0_exp  = rsp0.exp;
  assign q1_sum  = rsp1.sum;
  assign q1_cout = rsp1.cout;
  assign q1_sign = rsp1.sign;
  assign q1_exp  = rsp1.exp;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter with a behavioural adder
module tb_fp_add_arbiter;
  import fp_add_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear;
  logic        r0_valid, r0_ready, r0_cin, r0_sign;
  logic [31:0] r0_a, r0_b;
  logic [7:0]  r0_exp;
  logic        r1_valid, r1_ready, r1_cin, r1_sign;
  logic [31:0] r1_a, r1_b;
  logic [7:0]  r1_exp;
  logic [31:0] add_a, add_b, add_n1, add_n2, add_sum;
  logic        add_cin, add_s, add_cout, add_S;
  logic [7:0]  add_e, add_E;
  logic        q0_valid, q0_ready, q0_cout, q0_sign;
  logic [31:0] q0_sum;
  logic [7:0]  q0_exp;
  logic        q1_valid, q1_ready, q1_cout, q1_sign;
  logic [31:0] q1_sum;
  logic [7:0]  q1_exp;

  fp_add_arbiter dut (
    .clk(clk), .clear(clear),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_cin(r0_cin), .r0_sign(r0_sign), .r0_exp(r0_exp),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_cin(r1_cin), .r1_sign(r1_sign), .r1_exp(r1_exp),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_e(add_e),
    .add_n1(add_n1), .add_n2(add_n2),
    .add_sum(add_sum), .add_cout(add_cout), .add_S(add_S), .add_E(add_E),
    .q0_valid(q0_valid), .q0_ready(q0_ready), .q0_sum(q0_sum), .q0_cout(q0_cout),
    .q0_sign(q0_sign), .q0_exp(q0_exp),
    .q1_valid(q1_valid), .q1_ready(q1_ready), .q1_sum(q1_sum), .q1_cout(q1_cout),
    .q1_sign(q1_sign), .q1_exp(q1_exp)
  );

  // Adder model: captures at the issue edge, result on its outputs LAT-1 edges later.
  function automatic logic [41:0] adder_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic s, input logic [7:0] e);
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    return {t[31:0], t[32], s, e};
  endfunction

  logic [41:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= adder_model(add_a, add_b, add_cin, add_s, add_e);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign {add_sum, add_cout, add_S, add_E} = apipe[LAT-1];

  int          cyc = 0;
  int          acc0 = 0;
  int          acc1 = 0;
  int          q0_seen = 0;
  bit          overflow_seen = 1'b0;
  int          acc_cyc[$];
  int          pop_cyc[$];
  logic [41:0] q0_log[$];
  logic [41:0] q1_log[$];

  // Records what the next rising edge will transfer.
  always @(negedge clk) begin
    if (r0_valid && r0_ready) begin acc0++; acc_cyc.push_back(cyc); end
    if (r1_valid && r1_ready) begin acc1++; acc_cyc.push_back(cyc); end
    if (q0_valid && q0_ready) begin q0_log.push_back({q0_sum, q0_cout, q0_sign, q0_exp}); pop_cyc.push_back(cyc); end
    if (q1_valid && q1_ready) begin q1_log.push_back({q1_sum, q1_cout, q1_sign, q1_exp}); pop_cyc.push_back(cyc); end
    if (q0_valid) q0_seen++;
    if (!clear && dut.u_fifo0.push && dut.u_fifo0.count == DEPTH && !dut.u_fifo0.do_pop) overflow_seen = 1'b1;
    if (!clear && dut.u_fifo1.push && dut.u_fifo1.count == DEPTH && !dut.u_fifo1.do_pop) overflow_seen = 1'b1;
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int acc0_before;
  int seen_before;

  initial begin
    clear = 1'b1;
    r0_valid = 1'b1; r0_a = '0; r0_b = '0; r0_cin = 1'b0; r0_sign = 1'b0; r0_exp = '0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_cin = 1'b0; r1_sign = 1'b0; r1_exp = '0;
    q0_ready = 1'b0; q1_ready = 1'b0;
    tick(3);
    check("reset_r0_ready", r0_ready, 0);
    check("reset_q0_valid", q0_valid, 0);
    check("reset_q1_valid", q1_valid, 0);
    check("reset_q0_sum", q0_sum, 0);
    check("reset_add_a", add_a, 0);
    check("reset_cred0", dut.cred0, 8);

    // Single r0 op: 1 + 1 with sideband
    r0_a = 32'h1; r0_b = 32'h1; r0_cin = 1'b0; r0_exp = 8'h7F; r0_sign = 1'b1;
    q0_ready = 1'b1; q1_ready = 1'b1;
    clear = 1'b0;
    #1;
    check("t1_r0_ready", r0_ready, 1);
    check("t1_add_a", add_a, 32'h1);
    tick();
    r0_valid = 1'b0;
    tick(4);
    check("t1_q0_early", q0_valid, 0);
    tick();
    check("t1_q0_valid", q0_valid, 1);
    check("t1_q0_rsp", {q0_sum, q0_cout, q0_sign, q0_exp}, {32'h2, 1'b0, 1'b1, 8'h7F});
    tick();

    // Single r1 op with carry out
    seen_before = q0_seen;
    r1_a = 32'hFFFF_FFFF; r1_b = 32'h1; r1_cin = 1'b0; r1_exp = 8'h10; r1_sign = 1'b0;
    r1_valid = 1'b1;
    #1;
    check("t2_r1_ready", r1_ready, 1);
    tick();
    r1_valid = 1'b0;
    tick(5);
    check("t2_q1_valid", q1_valid, 1);
    check("t2_q1_rsp", {q1_sum, q1_cout, q1_sign, q1_exp}, {32'h0, 1'b1, 1'b0, 8'h10});
    tick();
    check("t2_q0_never", q0_seen - seen_before, 0);

    // Contention from reset: strict alternation and gap-free return
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q0_log.delete(); q1_log.delete(); acc_cyc.delete(); pop_cyc.delete();
    r0_a = 32'd100; r0_b = 32'd0; r1_a = 32'd200; r1_b = 32'd0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("t4_grant", {r0_ready, r1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      if (i % 2 == 0) r0_b = r0_b + 1;
      else r1_b = r1_b + 1;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick(10);
    check("t4_q0_count", q0_log.size(), 6);
    check("t4_q1_count", q1_log.size(), 6);
    for (int k = 0; k < 6 && k < q0_log.size() && k < q1_log.size(); k++) begin
      check("t4_q0_sum", q0_log[k][41:10], 100 + k);
      check("t4_q1_sum", q1_log[k][41:10], 200 + k);
    end
    check("t4_acc_span", acc_cyc[11] - acc_cyc[0], 11);
    for (int k = 0; k < 12 && k < pop_cyc.size() && k < acc_cyc.size(); k++) begin
      check("t4_latency", pop_cyc[k] - acc_cyc[k], 6);
    end

    // q0 back-pressured: credits cap r0 at DEPTH accepts while r1 keeps flowing
    clear = 1'b1;
    tick();
    clear = 1'b0;
    acc0 = 0;
    q0_ready = 1'b0; q1_ready = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    tick(30);
    check("t5_acc0_cap", acc0, 8);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_r1_only", {r0_ready, r1_ready}, 2'b01);
      tick();
    end
    acc0_before = acc0;
    q0_ready = 1'b1;
    tick();
    q0_ready = 1'b0;
    #1;
    check("t5_reassert", r0_ready, 1);
    tick(5);
    check("t5_one_more", acc0 - acc0_before, 1);
    check("t5_r0_blocked", r0_ready, 0);

    // Credit 1 with simultaneous issue and pop
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick(8);
    check("t6_fifo0_full", dut.u_fifo0.count, 8);
    q0_ready = 1'b1;
    tick();
    r0_valid = 1'b1;
    #1;
    check("t6_pre_cred", dut.cred0, 1);
    check("t6_pre_ready", r0_ready, 1);
    tick();
    check("t6_cred_hold", dut.cred0, 1);
    check("t6_ready_hold", r0_ready, 1);
    q0_ready = 1'b0;
    tick();
    check("t6_cred_zero", dut.cred0, 0);
    check("t6_ready_drop", r0_ready, 0);
    r0_valid = 1'b0;

    // clear with work both in the adder and in FIFO0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q0_ready = 1'b0; q1_ready = 1'b1;
    r0_a = 32'd10; r0_b = 32'd1; r0_valid = 1'b1;
    tick();
    r0_b = 32'd2;
    tick();
    r0_valid = 1'b0;
    tick(6);
    check("t7_fifo0_two", dut.u_fifo0.count, 2);
    r0_b = 32'd3; r0_valid = 1'b1;
    tick(3);
    r0_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("t7_quiet", {q0_valid, q1_valid}, 2'b00);
      tick();
    end
    check("t7_cred_restored", dut.cred0, 8);
    q0_ready = 1'b1;
    r0_a = 32'h1234_0000; r0_b = 32'h0000_5678; r0_cin = 1'b1; r0_exp = 8'h22; r0_sign = 1'b0;
    r0_valid = 1'b1;
    #1;
    check("t7_r0_ready", r0_ready, 1);
    tick();
    r0_valid = 1'b0;
    tick(4);
    check("t7_q0_early", q0_valid, 0);
    tick();
    check("t7_q0_valid", q0_valid, 1);
    check("t7_q0_rsp", {q0_sum, q0_cout, q0_sign, q0_exp}, {32'h1234_5679, 1'b0, 1'b0, 8'h22});
    tick(2);

    check("no_overflow", overflow_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
